result_capture: RTL and testbench

RESULT_CAPTURE -- requirements
Module: result_capture

---
 rtl/result_capture.sv | 108 ++++++++++
 tb/tb_result_capture.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/result_capture.sv
// result_capture: latches the first hasher-pool hit of a job, or flags the job
// as exhausted when the nonce space runs out without a hit. The pool pipeline
// needs FILL_CYCLES cycles to fill, and success is ignored during that time.
//
// Handshake: start_in and clear_in are single-cycle pulses. ready_out acts as
// the valid for result_out, found_out and exhausted_out. It stays high until
// the host acknowledges with clear_in, or until a new start_in arrives.
// start_in wins over every other input.
module result_capture #(
   parameter int NONCE_WIDTH    = 31,
   parameter int POOL_SIZE_LOG2 = 1,
   parameter int FILL_CYCLES    = 130
) (
   input  logic                      clk_in,
   input  logic                      reset_in,
   input  logic                      start_in,
   input  logic                      clear_in,
   input  logic                      success_in,
   input  logic [NONCE_WIDTH-1:0]    nonce_in,
   input  logic [POOL_SIZE_LOG2-1:0] unit_in,
   output logic [31:0]               result_out,
   output logic                      ready_out,
   output logic                      found_out,
   output logic                      exhausted_out,
   output logic                      busy_out,
   output logic [2:0]                state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FILL      = 3'd1,
      S_HASH      = 3'd2,
      S_FOUND     = 3'd3,
      S_EXHAUSTED = 3'd4
   } state_t;

   localparam logic [7:0] FILL_LOAD = 8'(FILL_CYCLES - 1);

   state_t     state;
   logic [7:0] fill_cnt;
   logic       nonce_last;

   // The last nonce of the job is reached when the nonce is all ones.
   assign nonce_last = &nonce_in;

   // The current state is exposed for debug and checker binding.
   assign state_dbg = state;

   // Job FSM: all outputs are registered alongside the state.
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state         <= S_IDLE;
         fill_cnt      <= 8'd0;
         result_out    <= 32'd0;
         ready_out     <= 1'b0;
         found_out     <= 1'b0;
         exhausted_out <= 1'b0;
         busy_out      <= 1'b0;
      end else if (start_in) begin
         // A new job restarts from any state. The captured result is kept.
         state         <= S_FILL;
         fill_cnt      <= FILL_LOAD;
         ready_out     <= 1'b0;
         found_out     <= 1'b0;
         exhausted_out <= 1'b0;
         busy_out      <= 1'b1;
      end else begin
         case (state)
            S_FILL: begin
               // The pipeline is still filling, so hits are not trusted yet.
               if (fill_cnt == 8'd0) begin
                  state <= S_HASH;
               end else begin
                  fill_cnt <= fill_cnt - 8'd1;
               end
            end
            S_HASH: begin
               // A hit beats exhaustion when both happen on the last nonce.
               if (success_in) begin
                  state      <= S_FOUND;
                  result_out <= {unit_in, nonce_in};
                  ready_out  <= 1'b1;
                  found_out  <= 1'b1;
                  busy_out   <= 1'b0;
               end else if (nonce_last) begin
                  state         <= S_EXHAUSTED;
                  ready_out     <= 1'b1;
                  exhausted_out <= 1'b1;
                  busy_out      <= 1'b0;
               end
            end
            S_FOUND, S_EXHAUSTED: begin
               // Hold the first result until the host acknowledges it.
               if (clear_in) begin
                  state         <= S_IDLE;
                  ready_out     <= 1'b0;
                  found_out     <= 1'b0;
                  exhausted_out <= 1'b0;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_result_capture.sv
// Testbench for result_capture. Two instances are driven with the same inputs:
// one with the default fill latency and one with a fill latency of one cycle.
// Both are compared every cycle against a reference model. The model tracks
// how many cycles have passed since the job started, and treats a cycle as
// hashing once that count exceeds the fill latency.
module tb_result_capture;

   localparam int NW = 31;
   localparam int UW = 1;
   localparam logic [NW-1:0] NONCE_MAX = {NW{1'b1}};

   int unsigned vectors    = 0;
   int unsigned miscompares = 0;

   logic          clk = 1'b0;
   logic          reset_in;
   logic          start_in;
   logic          clear_in;
   logic          success_in;
   logic [NW-1:0] nonce_in;
   logic [UW-1:0] unit_in;

   logic [31:0]   res0, res1;
   logic          rdy0, rdy1, fnd0, fnd1, exh0, exh1, bsy0, bsy1;
   logic [2:0]    st0, st1;

   // Reference model state, one slot per instance.
   int            fill_of [2] = '{130, 1};
   logic          m_active [2];
   int            m_since  [2];
   logic          m_ready  [2];
   logic          m_found  [2];
   logic          m_exh    [2];
   logic [31:0]   m_res    [2];

   result_capture #(.NONCE_WIDTH(NW), .POOL_SIZE_LOG2(UW), .FILL_CYCLES(130)) dut0 (
      .clk_in(clk), .reset_in(reset_in), .start_in(start_in), .clear_in(clear_in),
      .success_in(success_in), .nonce_in(nonce_in), .unit_in(unit_in),
      .result_out(res0), .ready_out(rdy0), .found_out(fnd0),
      .exhausted_out(exh0), .busy_out(bsy0), .state_dbg(st0)
   );

   result_capture #(.NONCE_WIDTH(NW), .POOL_SIZE_LOG2(UW), .FILL_CYCLES(1)) dut1 (
      .clk_in(clk), .reset_in(reset_in), .start_in(start_in), .clear_in(clear_in),
      .success_in(success_in), .nonce_in(nonce_in), .unit_in(unit_in),
      .result_out(res1), .ready_out(rdy1), .found_out(fnd1),
      .exhausted_out(exh1), .busy_out(bsy1), .state_dbg(st1)
   );

   // Clock generation
   always #5 clk = ~clk;

   // Checking task: counts the comparison and reports a mismatch.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_active[i] = 1'b0;
         m_since[i]  = 0;
         m_ready[i]  = 1'b0;
         m_found[i]  = 1'b0;
         m_exh[i]    = 1'b0;
         m_res[i]    = 32'd0;
      end
   endtask

   // One clock edge's worth of behaviour, as seen by the host.
   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         if (start_in) begin
            m_active[i] = 1'b1;
            m_since[i]  = 0;
            m_ready[i]  = 1'b0;
            m_found[i]  = 1'b0;
            m_exh[i]    = 1'b0;
         end else if (m_active[i]) begin
            m_since[i]++;
            if (m_since[i] > fill_of[i]) begin
               if (success_in) begin
                  m_res[i]    = {unit_in, nonce_in};
                  m_ready[i]  = 1'b1;
                  m_found[i]  = 1'b1;
                  m_active[i] = 1'b0;
               end else if (nonce_in == NONCE_MAX) begin
                  m_ready[i]  = 1'b1;
                  m_exh[i]    = 1'b1;
                  m_active[i] = 1'b0;
               end
            end
         end else if (clear_in && m_ready[i]) begin
            m_ready[i] = 1'b0;
            m_found[i] = 1'b0;
            m_exh[i]   = 1'b0;
         end
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "_res0"}, res0, m_res[0]);
      check({tag, "_rdy0"}, 32'(rdy0), 32'(m_ready[0]));
      check({tag, "_fnd0"}, 32'(fnd0), 32'(m_found[0]));
      check({tag, "_exh0"}, 32'(exh0), 32'(m_exh[0]));
      check({tag, "_bsy0"}, 32'(bsy0), 32'(m_active[0]));
      check({tag, "_res1"}, res1, m_res[1]);
      check({tag, "_rdy1"}, 32'(rdy1), 32'(m_ready[1]));
      check({tag, "_fnd1"}, 32'(fnd1), 32'(m_found[1]));
      check({tag, "_exh1"}, 32'(exh1), 32'(m_exh[1]));
      check({tag, "_bsy1"}, 32'(bsy1), 32'(m_active[1]));
   endtask

   // Driver: apply one cycle of inputs, step the model on the edge, check 1ns later.
   task automatic drive(input string tag, input logic st, input logic cl, input logic su,
                        input logic [NW-1:0] n, input logic [UW-1:0] u);
      start_in   = st;
      clear_in   = cl;
      success_in = su;
      nonce_in   = n;
      unit_in    = u;
      @(posedge clk);
      model_step();
      #1;
      check_all(tag);
   endtask

   function automatic logic [NW-1:0] rand_nonce();
      logic [NW-1:0] n;
      n = NW'($urandom);
      if (n == NONCE_MAX) n = NW'(0);
      return n;
   endfunction

   initial begin
      reset_in   = 1'b1;
      start_in   = 1'b0;
      clear_in   = 1'b0;
      success_in = 1'b0;
      nonce_in   = '0;
      unit_in    = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      reset_in = 1'b0;

      // Constant hit from the moment of start: the capture waits for the fill to finish.
      drive("s32_start", 1'b1, 1'b0, 1'b1, NW'(5), 1'b1);
      for (int k = 0; k < 140; k++) drive("s32_run", 1'b0, 1'b0, 1'b1, NW'(5), 1'b1);
      check("s32_result", res0, 32'h8000_0005);
      check("s32_found", 32'(fnd0), 32'd1);
      drive("s32_clear", 1'b0, 1'b1, 1'b0, NW'(0), 1'b0);

      // Sweep up to the last nonce with no hit.
      drive("s33_start", 1'b1, 1'b0, 1'b0, NW'(0), 1'b0);
      for (int k = 0; k < 130; k++) drive("s33_fill", 1'b0, 1'b0, 1'b0, rand_nonce(), 1'b0);
      for (int k = 0; k < 16; k++)
         drive("s33_sweep", 1'b0, 1'b0, 1'b0, NW'(32'h7FFF_FFF0 + 32'(k)), 1'b0);
      check("s33_exh", 32'(exh0), 32'd1);
      check("s33_fnd", 32'(fnd0), 32'd0);
      drive("s33_hold", 1'b0, 1'b0, 1'b1, NW'(9), 1'b1);
      drive("s33_clear", 1'b0, 1'b1, 1'b0, NW'(0), 1'b0);
      check("s33_rdy_clr", 32'(rdy0), 32'd0);

      // A hit on the last nonce counts as found. A later hit is ignored, and start beats clear.
      drive("s34_start", 1'b1, 1'b0, 1'b0, NW'(0), 1'b0);
      for (int k = 0; k < 130; k++) drive("s34_fill", 1'b0, 1'b0, 1'b0, rand_nonce(), 1'b0);
      drive("s34_hit", 1'b0, 1'b0, 1'b1, NONCE_MAX, 1'b0);
      check("s34_result", res0, 32'h7FFF_FFFF);
      check("s34_exh", 32'(exh0), 32'd0);
      drive("s35_second", 1'b0, 1'b0, 1'b1, NW'(32'h10), 1'b1);
      check("s35_hold", res0, 32'h7FFF_FFFF);
      drive("s35_restart", 1'b1, 1'b1, 1'b1, NW'(3), 1'b1);
      check("s35_busy", 32'(bsy0), 32'd1);
      check("s35_rdy", 32'(rdy0), 32'd0);

      // Reset asserted between edges while hashing.
      for (int k = 0; k < 135; k++) drive("s36_fill", 1'b0, 1'b0, 1'b0, rand_nonce(), 1'b0);
      #2;
      reset_in = 1'b1;
      #1;
      model_reset();
      check_all("s36_async");
      #1;
      reset_in = 1'b0;
      for (int k = 0; k < 10; k++) drive("s36_after", 1'b0, 1'b0, 1'b1, NW'(7), 1'b1);

      // Random traffic: occasional starts, clears, hits and end-of-space nonces.
      for (int k = 0; k < 3000; k++) begin
         logic          st, cl, su;
         logic [NW-1:0] n;
         st = ($urandom_range(0, 299) == 0);
         cl = ($urandom_range(0, 19) == 0);
         su = ($urandom_range(0, 49) == 0);
         n  = ($urandom_range(0, 39) == 0) ? NONCE_MAX : rand_nonce();
         drive("rand", st, cl, su, n, UW'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
